// File: rtl/rv32v_operand_sequencer.sv
// rv32v_operand_sequencer: walks one vector source register group by group.
// Each read row-address goes to the four 32-bit VRF banks. The matching
// offset, mask and element index are registered so that they line up with
// the bank data one cycle later. Lanes see a valid/ready stream of 4-element
// groups, with a tail mask.
// veew encoding: 0 = SEW8, 1 = SEW16, 2 = SEW32 (3 is treated as SEW32).
// Optional feature: define RV32V_SEQ_PERF_EN to add the stall_cnt output.
module rv32v_operand_sequencer #(
  parameter int VLEN   = 128,
  parameter int NBANKS = 4
) (
  input  logic                                CLK,
  input  logic                                nRST,
  input  logic                                start,
  input  logic [4:0]                          vs,
  input  logic [$clog2(VLEN/8):0]             vl,
  input  logic [1:0]                          veew,
  input  logic                                sign_ext,
  output logic                                bank_ren,
  output logic [$clog2(32*(VLEN/128))-1:0]    bank_raddr,
  output logic [1:0]                          bank_offset,
  output logic [1:0]                          veew_q,
  output logic                                sign_ext_q,
  output logic                                lane_valid,
  output logic [NBANKS-1:0]                   lane_mask,
  output logic [$clog2(VLEN/8)-1:0]           elem_idx,
  input  logic                                lane_ready,
  output logic                                busy,
  output logic                                done
`ifdef RV32V_SEQ_PERF_EN
  ,
  output logic [15:0]                         stall_cnt
`endif
);
  localparam int ROWS = VLEN / 128;
  localparam int AW   = $clog2(32 * ROWS);
  localparam int EW   = $clog2(VLEN / 8);
  localparam int GW   = $clog2(VLEN / 32) + 1;
  localparam logic [1:0] SEW8 = 2'd0, SEW16 = 2'd1, SEW32 = 2'd2;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [GW-1:0]     g_q, g_d, glast_q, row;
  logic [4:0]        vs_q;
  logic [EW:0]       vl_q;
  logic [1:0]        off;
  logic [NBANKS-1:0] mask_d;
  logic [EW-1:0]     idx_d;
  logic              issue, accept, start_acc, done_d;

  assign start_acc = (state_q == IDLE) && start;
  assign accept    = lane_valid && lane_ready;
  // A new read may go out only if the output slot is empty or is being drained this cycle.
  assign issue     = (state_q == RUN) && (!lane_valid || lane_ready);
  assign busy      = (state_q != IDLE);
  assign bank_ren  = issue;
  assign bank_raddr = issue ? AW'(int'(vs_q) * ROWS + int'(row)) : '0;
  assign idx_d     = EW'(int'(g_q) * NBANKS);

  // Map group number to row and byte offset within the 32-bit bank word for the latched SEW.
  always_comb begin
    row = g_q;
    off = 2'd0;
    case (veew_q)
      SEW8:    begin row = g_q >> 2; off = g_q[1:0];       end
      SEW16:   begin row = g_q >> 1; off = {g_q[0], 1'b0}; end
      default: begin row = g_q;      off = 2'd0;           end
    endcase
  end

  // Tail mask: lane i is live iff its element index is below vl.
  always_comb begin
    mask_d = '0;
    for (int i = 0; i < NBANKS; i++)
      mask_d[i] = (int'(g_q) * NBANKS + i) < int'(vl_q);
  end

  // FSM next-state, group counter and done pulse request.
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        g_d = '0;
        if (vl == '0) done_d  = 1'b1;
        else          state_d = RUN;
      end
      RUN: if (issue) begin
        g_d = g_q + GW'(1);
        if (g_q == glast_q) state_d = DRAIN;
      end
      DRAIN: if (accept) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, group counter and registered done pulse.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      g_q     <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      done    <= done_d;
    end
  end

  // Operand fields are captured on an accepted start and held until the next one.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      vs_q       <= '0;
      vl_q       <= '0;
      veew_q     <= SEW32;
      sign_ext_q <= 1'b0;
      glast_q    <= '0;
    end else if (start_acc) begin
      vs_q       <= vs;
      vl_q       <= vl;
      veew_q     <= veew;
      sign_ext_q <= sign_ext;
      glast_q    <= GW'((int'(vl) + NBANKS - 1) / NBANKS - 1);
    end
  end

  // Per-group sideband is delayed one cycle from the read so it matches bank data.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      bank_offset <= 2'd0;
      lane_mask   <= '0;
      elem_idx    <= '0;
      lane_valid  <= 1'b0;
    end else begin
      if (issue) begin
        bank_offset <= off;
        lane_mask   <= mask_d;
        elem_idx    <= idx_d;
      end
      if (issue)       lane_valid <= 1'b1;
      else if (accept) lane_valid <= 1'b0;
    end
  end

`ifdef RV32V_SEQ_PERF_EN
  // Saturating count of cycles where lanes hold off a valid group.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                                                     stall_cnt <= '0;
    else if (start_acc)                                            stall_cnt <= '0;
    else if (lane_valid && !lane_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule
